processor_8085_multi: RTL and testbench

PROCESSOR_8085_MULTI -- requirements
Module: processor_8085_multi

---
 rtl/processor_8085_multi.sv | 174 +++++++++++++++++
 tb/tb_processor_8085_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_8085_multi.sv
// Multi-cycle 8085-flavoured accumulator core: FETCH -> DECODE -> EXEC, three cycles per instruction.
// A single-word instruction memory is read combinationally through imem_addr/imem_data.
module processor_8085_multi #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 7,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [DATA_W-1:0] acc,
    output logic              cy,
    output logic              z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted
);

    localparam int unsigned SUM_W = DATA_W + 1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MVI = 4'h1;
    localparam logic [3:0] OP_MVA = 4'h2;
    localparam logic [3:0] OP_MVR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_ANA = 4'h6;
    localparam logic [3:0] OP_ORA = 4'h7;
    localparam logic [3:0] OP_XRA = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_ADI = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] regfile [NREGS];

    logic [3:0]        op_c;
    logic [2:0]        rsel_c;
    logic [DATA_W-1:0] imm_d_c;
    logic [PC_W-1:0]   imm_p_c;
    logic              ir_unused_c;
    logic [DATA_W-1:0] rd_c;
    logic [DATA_W-1:0] addb_c;
    logic [SUM_W-1:0]  add_c;
    logic [SUM_W-1:0]  sub_c;
    logic [DATA_W-1:0] and_c;
    logic [DATA_W-1:0] or_c;
    logic [DATA_W-1:0] xor_c;

    assign imem_addr   = pc;
    assign op_c        = ir[15:12];
    assign rsel_c      = ir[10:8];
    assign imm_d_c     = DATA_W'(ir[7:0]);
    assign imm_p_c     = PC_W'(ir[7:0]);
    assign ir_unused_c = ir[11];

    // Register read; indices beyond the implemented file read as zero.
    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(rsel_c) == i) begin
                rd_c = regfile[i];
            end
        end
    end

    // ALU: the sum/difference carry an extra bit so its MSB is carry/borrow.
    always_comb begin
        addb_c = (op_c == OP_ADI) ? imm_d_c : operand;
        add_c  = SUM_W'(acc) + SUM_W'(addb_c);
        sub_c  = SUM_W'(acc) - SUM_W'(operand);
        and_c  = acc & operand;
        or_c   = acc | operand;
        xor_c  = acc ^ operand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            operand   <= '0;
            acc       <= '0;
            cy        <= 1'b0;
            z         <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    ir    <= imem_data;
                    pc    <= pc + PC_W'(1);
                    state <= DECODE;
                end
                DECODE: begin
                    operand <= rd_c;
                    state   <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    case (op_c)
                        OP_MVI: acc <= imm_d_c;
                        OP_MVA: acc <= operand;
                        OP_MVR: begin
                            for (int unsigned i = 0; i < NREGS; i++) begin
                                if (32'(rsel_c) == i) begin
                                    regfile[i] <= acc;
                                end
                            end
                        end
                        OP_ADD, OP_ADI: begin
                            acc <= add_c[DATA_W-1:0];
                            cy  <= add_c[DATA_W];
                            z   <= (add_c[DATA_W-1:0] == '0);
                        end
                        OP_SUB, OP_CMP: begin
                            if (op_c == OP_SUB) begin
                                acc <= sub_c[DATA_W-1:0];
                            end
                            cy <= sub_c[DATA_W];
                            z  <= (sub_c[DATA_W-1:0] == '0);
                        end
                        OP_ANA: begin
                            acc <= and_c;
                            cy  <= 1'b0;
                            z   <= (and_c == '0);
                        end
                        OP_ORA: begin
                            acc <= or_c;
                            cy  <= 1'b0;
                            z   <= (or_c == '0);
                        end
                        OP_XRA: begin
                            acc <= xor_c;
                            cy  <= 1'b0;
                            z   <= (xor_c == '0);
                        end
                        OP_JMP: pc <= imm_p_c;
                        OP_JZ:  if (z)  pc <= imm_p_c;
                        OP_JC:  if (cy) pc <= imm_p_c;
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_HLT: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        OP_NOP: ;
                        default: ;
                    endcase
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_8085_multi.sv
// Bench for processor_8085_multi: instruction-level reference model compared every cycle,
// plus directed programs with hand-computed results and randomized programs.
module tb_processor_8085_multi;

    localparam int NR = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  acc;
    logic        cy;
    logic        z;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        halted;

    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr];

    processor_8085_multi #(.DATA_W(8), .NREGS(NR), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .acc(acc), .cy(cy), .z(z), .out_data(out_data), .out_valid(out_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction every three cycles, executed whole at its last cycle.
    int          m_pc, m_acc, m_cy, m_z, m_out, m_ov, m_halt, m_phase;
    int          m_reg [8];
    logic [15:0] m_ir;

    task automatic model_exec();
        int op, r, imm, rv, res;
        op  = int'(m_ir[15:12]);
        r   = int'(m_ir[10:8]);
        imm = int'(m_ir[7:0]);
        rv  = (r < NR) ? m_reg[r] : 0;
        case (op)
            1: m_acc = imm;
            2: m_acc = rv;
            3: if (r < NR) m_reg[r] = m_acc;
            4, 10: begin
                res   = m_acc + ((op == 4) ? rv : imm);
                m_cy  = (res > 255) ? 1 : 0;
                m_acc = res % 256;
                m_z   = (m_acc == 0) ? 1 : 0;
            end
            5, 9: begin
                m_cy = (m_acc < rv) ? 1 : 0;
                res  = (m_acc - rv + 256) % 256;
                m_z  = (res == 0) ? 1 : 0;
                if (op == 5) m_acc = res;
            end
            6, 7, 8: begin
                res   = (op == 6) ? (m_acc & rv) : (op == 7) ? (m_acc | rv) : (m_acc ^ rv);
                m_cy  = 0;
                m_acc = res;
                m_z   = (res == 0) ? 1 : 0;
            end
            11: m_pc = imm;
            12: if (m_z == 1) m_pc = imm;
            13: if (m_cy == 1) m_pc = imm;
            14: begin m_out = m_acc; m_ov = 1; end
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_acc = 0; m_cy = 0; m_z = 0; m_out = 0; m_ov = 0;
            m_halt = 0; m_phase = 0; m_ir = 16'h0;
            for (int i = 0; i < 8; i++) m_reg[i] = 0;
        end else begin
            m_ov = 0;
            if (m_halt == 0) begin
                case (m_phase)
                    0: begin m_ir = mem[m_pc]; m_pc = (m_pc + 1) % 256; m_phase = 1; end
                    1: m_phase = 2;
                    default: begin model_exec(); m_phase = 0; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("acc", longint'(acc), longint'(m_acc));
            chk("cy", longint'(cy), longint'(m_cy));
            chk("z", longint'(z), longint'(m_z));
            chk("out_data", longint'(out_data), longint'(m_out));
            chk("out_valid", longint'(out_valid), longint'(m_ov));
            chk("halted", longint'(halted), longint'(m_halt));
            chk("imem_addr", longint'(imem_addr), longint'(m_pc));
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, " acc"}, longint'(acc), 0);
        chk({tag, " cy"}, longint'(cy), 0);
        chk({tag, " z"}, longint'(z), 0);
        chk({tag, " out_data"}, longint'(out_data), 0);
        chk({tag, " out_valid"}, longint'(out_valid), 0);
        chk({tag, " halted"}, longint'(halted), 0);
        chk({tag, " pc"}, longint'(imem_addr), 0);
        for (int i = 0; i < NR; i++) chk({tag, " regfile"}, longint'(dut.regfile[i]), 0);
    endtask

    initial begin
        logic [15:0] w;
        clear_mem();
        @(negedge clk); #1;
        chk_zero_state("reset");
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // MVI F0; ADI 20; HLT
        clear_mem();
        mem[0] = 16'h10F0; mem[1] = 16'hA020; mem[2] = 16'hF000;
        do_reset(); cycles(9);
        chk("p1 acc", longint'(acc), 'h10);
        chk("p1 cy", longint'(cy), 1);
        chk("p1 z", longint'(z), 0);
        chk("p1 halted", longint'(halted), 1);
        chk("p1 pc", longint'(imem_addr), 3);
        chk("p1 model acc", longint'(m_acc), 'h10);
        cycles(6);
        chk("p1 pc frozen", longint'(imem_addr), 3);

        // MVI 5; MOV r0=acc; MVI 3; SUB r0; MVI 5; CMP r0; HLT
        clear_mem();
        mem[0] = 16'h1005; mem[1] = 16'h3000; mem[2] = 16'h1003; mem[3] = 16'h5000;
        mem[4] = 16'h1005; mem[5] = 16'h9000; mem[6] = 16'hF000;
        do_reset(); cycles(12);
        chk("p2 sub acc", longint'(acc), 'hFE);
        chk("p2 sub cy", longint'(cy), 1);
        chk("p2 sub z", longint'(z), 0);
        cycles(6);
        chk("p2 cmp acc", longint'(acc), 5);
        chk("p2 cmp z", longint'(z), 1);
        chk("p2 cmp cy", longint'(cy), 0);
        chk("p2 model cmp z", longint'(m_z), 1);

        // MVI 0; ORA r0; JZ 10  (taken), then MVI 1 variant (not taken)
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h7000; mem[2] = 16'hC010;
        do_reset(); cycles(9);
        chk("p3 jz taken pc", longint'(imem_addr), 'h10);
        mem[0] = 16'h1001;
        do_reset(); cycles(9);
        chk("p3 jz not taken pc", longint'(imem_addr), 3);

        // MVI 5A; OUT; HLT
        clear_mem();
        mem[0] = 16'h105A; mem[1] = 16'hE000; mem[2] = 16'hF000;
        do_reset(); cycles(6);
        chk("p4 out_data", longint'(out_data), 'h5A);
        chk("p4 out_valid high", longint'(out_valid), 1);
        chk("p4 cy", longint'(cy), 0);
        chk("p4 z", longint'(z), 0);
        cycles(1);
        chk("p4 out_valid low", longint'(out_valid), 0);

        // pc wrap over an all-NOP memory
        clear_mem();
        do_reset(); cycles(3 * 255);
        chk("p5 pc 255", longint'(imem_addr), 255);
        cycles(1);
        chk("p5 pc wrap", longint'(imem_addr), 0);

        // MVI 77; MOV r7=acc (ignored); MOV acc=r7 -> 0
        mem[0] = 16'h1077; mem[1] = 16'h3700; mem[2] = 16'h2700; mem[3] = 16'hF000;
        do_reset(); cycles(9);
        chk("p5 r7 reads zero", longint'(acc), 0);

        // MVI 3; MOV r1=acc; ADD r1; HLT with resets in DECODE of ADD and in HALT
        clear_mem();
        mem[0] = 16'h1003; mem[1] = 16'h3100; mem[2] = 16'h4100; mem[3] = 16'hF000;
        do_reset(); cycles(7);
        chk("p6 pre acc", longint'(acc), 3);
        chk("p6 pre r1", longint'(dut.regfile[1]), 3);
        rst = 1'b1; #2;
        chk_zero_state("p6 rst decode");
        @(negedge clk); #2 rst = 1'b0;
        cycles(12);
        chk("p6 rerun acc", longint'(acc), 6);
        chk("p6 rerun halted", longint'(halted), 1);
        rst = 1'b1; #2;
        chk_zero_state("p6 rst halt");
        @(negedge clk); #2 rst = 1'b0;
        cycles(3);
        chk("p6 restart pc", longint'(imem_addr), 1);

        // Randomized programs, some with an asynchronous reset mid-run
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hF && ($urandom % 6) != 0) w[15:12] = 4'h0;
                mem[i] = w;
            end
            do_reset();
            if (it % 2 == 1) begin
                cycles(int'($urandom_range(20, 150)));
                rst = 1'b1; #2 rst = 1'b0;
            end
            cycles(300);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
